// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around a single one-bit Full_adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (a - b via inverted B and carry-in of 1).

module Full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             cell_s, cell_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    Full_adder u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry_reg),
        .S    (cell_s),
        .Cout (cell_cout)
    );

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b_load;
                        carry_reg <= carry_load;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= StRun;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StRun: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    res_sr    <= {cell_s, res_sr[WIDTH-1:1]};
                    carry_reg <= cell_cout;
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry_reg here is the carry into the MSB
                        sum   <= {cell_s, res_sr[WIDTH-1:1]};
                        cout  <= cell_cout;
                        ovf   <= carry_reg ^ cell_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
// Exercises the sub port when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout, ovf;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input bit ms);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic         v;
        bb   = ms ? ~mb : mb;
        c    = ms ? 1'b1 : mc;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {v, full};
    endfunction

    task automatic set_sub(input bit s);
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input bit ts, input bit noise, input string tag);
        logic [W+1:0] exp;
        int busy_cnt;
        int done_at;
        exp = model(ta, tb_v, tc, ts);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; set_sub(ts); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        set_sub(1'($urandom));
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 3 * W && done_at == 0; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_at = k;
            if (noise && busy && k < W) begin
                start = 1'b1;
                a     = 8'h11;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, 64'(done_at), 64'(W + 1));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
        check({tag, " cout"}, 64'(cout), 64'(exp[W]));
        check({tag, " ovf"}, 64'(ovf), 64'(exp[W+1]));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] bb_a [4];
        logic [W-1:0] bb_b [4];
        logic [W+1:0] exp;
        int cnt;
        int dones;
        bb_a = '{8'h01, 8'h7F, 8'h01, 8'h7F};
        bb_b = '{8'h01, 8'h01, 8'h01, 8'h01};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset sum", 64'(sum), 64'(0));
        check("reset cout_ovf", 64'({cout, ovf}), 64'(0));
        rst_n = 1'b1;

        run_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0, "add3c45");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "addff01");
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "addff00c");
        run_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b1, "ignore_start");

        // Reset mid-RUN discards the operation
        @(negedge clk);
        a = 8'h3C; b = 8'h45; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        check("midrst sum", 64'(sum), 64'(0));
        check("midrst cout_ovf", 64'({cout, ovf}), 64'(0));
        dones = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst no_activity", 64'(dones), 64'(0));
        run_op(8'h02, 8'h03, 1'b0, 1'b0, 1'b0, "after_rst");

        // start held high: one result every W+1 cycles
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = model(bb_a[i], bb_b[i], 1'b0, 1'b0);
            cnt = 0;
            for (int k = 1; k <= 3 * W; k++) begin
                @(negedge clk);
                if (done) begin
                    cnt = k;
                    break;
                end
            end
            check($sformatf("b2b%0d period", i), 64'(cnt), 64'(W + 1));
            check($sformatf("b2b%0d sum", i), 64'(sum), 64'(exp[W-1:0]));
            check($sformatf("b2b%0d ovf", i), 64'(ovf), 64'(exp[W+1]));
            if (i < 3) begin
                a = bb_a[i+1]; b = bb_b[i+1];
            end else begin
                start = 1'b0;
            end
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, "sub1020");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, "sub8001");
`endif

        for (int i = 0; i < 20; i++) begin
            bit s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), s, 1'($urandom),
                   $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
